// File: rtl/logic_unit_pkg.sv
// Shared types and the per-bit logic function for the sequential logic unit.
// Optional feature macro used by the top: LOGIC_UNIT_POPCNT_EN (adds popcnt output).
package logic_unit_pkg;

    // Operation codes, sampled on operand accept
    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_ANDN  = 3'b100,
        OP_ORN   = 3'b101,
        OP_XNOR  = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Evaluates the selected op on one bit position; the slice evaluator
    // replicates this across its CHUNK lanes, so any slice width works
    // without a width-specific function.
    function automatic logic lu_op_bit(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOR:   r = ~(a | b);
            OP_ANDN:  r = a & ~b;
            OP_ORN:   r = a | ~b;
            OP_XNOR:  r = ~(a ^ b);
            default:  r = a;  // OP_PASSA
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational CHUNK-wide op evaluator with slice zero detect.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  op_e              op,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] res,
    output logic             zero
);

    // One op lane per bit of the slice
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_lane
        assign res[gi] = lu_op_bit(op, a[gi], b[gi]);
    end

    assign zero = ~|res;

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: processes CHUNK bits per clock over
// WIDTH/CHUNK cycles, valid/ready on both sides, with a zero flag.
// Optional feature: define LOGIC_UNIT_POPCNT_EN to add the popcnt output
// (number of 1 bits in res, accumulated per slice).
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero
`ifdef LOGIC_UNIT_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    state_e             state_reg;
    op_e                op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               zero_acc_reg;
    logic [WIDTH-1:0]   res_reg;
    logic [WIDTH-1:0]   res_next;
    logic               zero_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;

    logic [CHUNK-1:0]   a_chunks [NCHUNK];
    logic [CHUNK-1:0]   b_chunks [NCHUNK];
    logic [CHUNK-1:0]   a_slice;
    logic [CHUNK-1:0]   b_slice;
    logic [CHUNK-1:0]   slice_res;
    logic               slice_zero;

    // Split the latched operands into chunk views and build the result
    // image with the current slice replaced by the evaluator output
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
        assign res_next[gi*CHUNK +: CHUNK] =
            (cnt_reg == CNT_W'(gi)) ? slice_res : res_reg[gi*CHUNK +: CHUNK];
    end

    // Counter-indexed slice mux feeding the single evaluator
    assign a_slice = a_chunks[cnt_reg];
    assign b_slice = b_chunks[cnt_reg];

    logic_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .op   (op_reg),
        .a    (a_slice),
        .b    (b_slice),
        .res  (slice_res),
        .zero (slice_zero)
    );

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int PC_W = $clog2(WIDTH + 1);

    logic [PC_W-1:0] popcnt_reg;
    logic [PC_W-1:0] slice_pop;

    // Number of set bits in the slice being written this cycle
    always_comb begin
        slice_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            slice_pop = slice_pop + PC_W'(slice_res[i]);
        end
    end

    assign popcnt = popcnt_reg;
`endif

    // Control FSM: accept operands, walk the slices, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_AND;
            a_reg         <= '0;
            b_reg         <= '0;
            cnt_reg       <= '0;
            zero_acc_reg  <= 1'b0;
            res_reg       <= '0;
            zero_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef LOGIC_UNIT_POPCNT_EN
            popcnt_reg    <= '0;
`endif
        end else if (flush) begin
            // Abort wins over accept and delivery; res keeps stale content
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef LOGIC_UNIT_POPCNT_EN
            popcnt_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        op_reg       <= op_e'(op);
                        cnt_reg      <= '0;
                        zero_acc_reg <= 1'b1;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_RUN;
`ifdef LOGIC_UNIT_POPCNT_EN
                        popcnt_reg   <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    res_reg      <= res_next;
                    zero_acc_reg <= zero_acc_reg & slice_zero;
`ifdef LOGIC_UNIT_POPCNT_EN
                    popcnt_reg   <= popcnt_reg + slice_pop;
`endif
                    if (cnt_reg == LAST_CNT) begin
                        cnt_reg       <= '0;
                        zero_reg      <= zero_acc_reg & slice_zero;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign res       = res_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq (WIDTH=32, CHUNK=8) plus a
// single-chunk instance (CHUNK=32). Popcnt is checked when
// LOGIC_UNIT_POPCNT_EN is defined.
module tb_logic_unit_seq;
    import logic_unit_pkg::*;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, zero;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i, res;

    logic        in_valid1, in_ready1, flush1, out_valid1, out_ready1, zero1;
    logic [2:0]  op1;
    logic [31:0] a1, b1, res1;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [5:0]  popcnt, popcnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    logic_unit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_i),
        .a         (a_i),
        .b         (b_i),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .zero      (zero)
`ifdef LOGIC_UNIT_POPCNT_EN
        ,
        .popcnt    (popcnt)
`endif
    );

    logic_unit_seq #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .op        (op1),
        .a         (a1),
        .b         (b1),
        .flush     (flush1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .res       (res1),
        .zero      (zero1)
`ifdef LOGIC_UNIT_POPCNT_EN
        ,
        .popcnt    (popcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference for each op
    function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a | b);
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            3'b110:  return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Timeline model: an accepted op becomes visible NCHUNK edges later and
    // stays until taken; flush or reset discards it.
    logic        m_busy, m_have;
    int          m_left;
    logic [31:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_have <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
        end else if (flush) begin
            m_busy <= 1'b0;
            m_have <= 1'b0;
        end else if (m_have) begin
            if (out_ready) begin
                m_have <= 1'b0;
                m_busy <= 1'b0;
            end
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_have <= 1'b1;
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_left <= NCHUNK;
            m_res  <= model_op(op_i, a_i, b_i);
        end
    end

    // Per-cycle compare against the model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk1("cyc_in_ready", in_ready, !m_busy);
            chk1("cyc_out_valid", out_valid, m_have);
            if (m_have) begin
                chk32("cyc_res", res, m_res);
                chk1("cyc_zero", zero, (m_res == 32'd0));
`ifdef LOGIC_UNIT_POPCNT_EN
                chk32("cyc_popcnt", 32'(popcnt), 32'($countones(m_res)));
`endif
            end
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        @(posedge clk);
        #1;
        @(negedge clk);
        in_valid = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
    endtask

    // Waits (bounded) for out_valid and pins latency and result literals
    task automatic wait_result(input string name, input logic [31:0] exp_res, input logic exp_zero);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk32({name, "_latency"}, n, NCHUNK);
        chk32({name, "_res"}, res, exp_res);
        chk1({name, "_zero"}, zero, exp_zero);
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1({name, "_rel_out_valid"}, out_valid, 1'b0);
        chk1({name, "_rel_in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
        start_op(op, a, b);
        wait_result(name, exp_res, exp_zero);
        release_result(name);
        $display("op %s: a=%h b=%h res=%h zero=%b", name, a, b, res, zero);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        op_i = '0; a_i = '0; b_i = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; flush1 = 1'b0;
        op1 = '0; a1 = '0; b1 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_res", res, 32'h0);
        chk1("rst_zero", zero, 1'b0);
        $display("reset: in_ready=%b out_valid=%b res=%h", in_ready, out_valid, res);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_op("and",  3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        run_op("nor",  3'b011, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1);
        run_op("xnor", 3'b110, 32'hA5A5C3C3, 32'hA5A5C3C3, 32'hFFFFFFFF, 1'b0);
        run_op("orn",  3'b101, 32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 1'b0);

        // Backpressure: result held, second request ignored
        start_op(3'b001, 32'h12340000, 32'h00005678);
        wait_result("bp", 32'h12345678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            op_i = 3'b000;
            a_i = 32'hFFFFFFFF;
            b_i = 32'hFFFFFFFF;
            @(posedge clk);
            #1;
            chk32("bp_hold_res", res, 32'h12345678);
            chk1("bp_hold_zero", zero, 1'b0);
            chk1("bp_hold_in_ready", in_ready, 1'b0);
            chk1("bp_hold_out_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_result("bp");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk1("bp_no_second_op", out_valid, 1'b0);
        end
        $display("backpressure: res held=%h, second op dropped", 32'h12345678);

        // Flush at the edge that processes slice 2
        start_op(3'b010, 32'h1234ABCD, 32'hFFFFFFFF);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk1("flush_in_ready", in_ready, 1'b1);
        chk1("flush_out_valid", out_valid, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk1("flush_no_result", out_valid, 1'b0);
        end
        // Flush together with a request in IDLE: nothing accepted
        @(negedge clk);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk1("flush_blocks_accept", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        $display("flush: aborted mid-run, accept blocked");
        run_op("andn", 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000, 1'b0);

        // Asynchronous reset mid-RUN
        start_op(3'b001, 32'h00FF00FF, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_in_ready", in_ready, 1'b1);
        chk1("arst_out_valid", out_valid, 1'b0);
        chk32("arst_res", res, 32'h0);
        chk1("arst_zero", zero, 1'b0);
        $display("async reset: res=%h in_ready=%b", res, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("passa", 3'b111, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0);

        // Single-chunk instance: RUN lasts one edge
        @(negedge clk);
        in_valid1 = 1'b1;
        op1 = 3'b010;
        a1 = 32'hFFFF0000;
        b1 = 32'h00000000;
        @(posedge clk);
        #1;
        chk1("c1_accept_in_ready", in_ready1, 1'b0);
        chk1("c1_run_out_valid", out_valid1, 1'b0);
        @(negedge clk);
        in_valid1 = 1'b0;
        @(posedge clk);
        #1;
        chk1("c1_out_valid", out_valid1, 1'b1);
        chk32("c1_res", res1, 32'hFFFF0000);
        chk1("c1_zero", zero1, 1'b0);
`ifdef LOGIC_UNIT_POPCNT_EN
        chk32("c1_popcnt", 32'(popcnt1), 32'd16);
`endif
        @(negedge clk);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        chk1("c1_rel_in_ready", in_ready1, 1'b1);
        chk1("c1_rel_out_valid", out_valid1, 1'b0);
        @(negedge clk);
        out_ready1 = 1'b0;
        $display("chunk1: xor res=%h zero=%b", res1, zero1);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
